// File: rtl/wombat_pkt_stats.sv
`default_nettype none
// ============================================================================
// Module  : wombat_pkt_stats
// Purpose : Passive statistics monitor for the datapath. It counts completed
//           ingress and egress AXI-Stream packets and latches the latest
//           accelerator result. Each value is held until wombat_cpu_regs
//           sends its clear-on-read pulse.
// Revision: 1.0 - initial release
// ============================================================================
module wombat_pkt_stats #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_tvalid,
  input  logic                 in_tready,
  input  logic                 in_tlast,
  input  logic                 out_tvalid,
  input  logic                 out_tready,
  input  logic                 out_tlast,
  input  logic                 result_valid,
  input  logic [31:0]          result_data,
  input  logic                 pktin_reg_clear,
  input  logic                 pktout_reg_clear,
  input  logic                 return_value_clear,
  output logic [CNT_WIDTH-1:0] pktin_reg,
  output logic [CNT_WIDTH-1:0] pktout_reg,
  output logic [31:0]          return_value,
  output logic                 result_pending,
  output logic                 pkt_in_flight
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // Index 0 is the ingress stream, index 1 is the egress stream.
  logic [1:0] w_beat;
  logic [1:0] w_eop;
  logic [1:0] w_clear;

  assign w_beat  = {out_tvalid & out_tready, in_tvalid & in_tready};
  assign w_eop   = w_beat & {out_tlast, in_tlast};
  assign w_clear = {pktout_reg_clear, pktin_reg_clear};

  for (genvar s = 0; s < 2; s++) begin : g_stream
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_base;
    logic [CNT_WIDTH-1:0] w_next;

    // Next count: a clear zeroes the base first so a coincident packet end
    // still registers as 1; saturation only applies to an uncleared count.
    always_comb begin
      w_base = w_clear[s] ? '0 : r_cnt;
      w_next = w_base;
      if (w_eop[s]) begin
        if (SATURATE && !w_clear[s] && (&r_cnt)) begin
          w_next = r_cnt;
        end else begin
          w_next = w_base + CNT_WIDTH'(1);
        end
      end
    end

    // Packet framing state and completed-packet counter for this stream.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        if (w_beat[s]) begin
          r_state <= w_eop[s] ? ST_IDLE : ST_IN_PKT;
        end
        r_cnt <= w_next;
      end
    end
  end

  assign pktin_reg     = g_stream[0].r_cnt;
  assign pktout_reg    = g_stream[1].r_cnt;
  assign pkt_in_flight = (g_stream[0].r_state == ST_IN_PKT);

  // Result latch: a new result beats a coincident clear, last result wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      return_value   <= '0;
      result_pending <= 1'b0;
    end else if (result_valid) begin
      return_value   <= result_data;
      result_pending <= 1'b1;
    end else if (return_value_clear) begin
      return_value   <= '0;
      result_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wombat_pkt_stats.sv
`default_nettype none
// ============================================================================
// Module  : tb_wombat_pkt_stats
// Purpose : Directed bench for wombat_pkt_stats. Stimulus queues expected
//           values tagged with the cycle they must appear; a monitor pops and
//           compares them. Two narrow 3-bit instances share the ingress stream
//           so the saturate and wrap behaviour can be reached quickly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wombat_pkt_stats;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
  logic        out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic        result_valid = 1'b0;
  logic [31:0] result_data = '0;
  logic        pktin_reg_clear = 1'b0, pktout_reg_clear = 1'b0, return_value_clear = 1'b0;

  logic [31:0] pktin_reg, pktout_reg, return_value;
  logic        result_pending, pkt_in_flight;
  logic [2:0]  s_pktin, s_pktout, w_pktin, w_pktout;
  logic [31:0] s_rv, w_rv;
  logic        s_pend, s_fl, w_pend, w_fl;

  wombat_pkt_stats #(.CNT_WIDTH(32), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .result_valid(result_valid), .result_data(result_data),
    .pktin_reg_clear(pktin_reg_clear), .pktout_reg_clear(pktout_reg_clear),
    .return_value_clear(return_value_clear),
    .pktin_reg(pktin_reg), .pktout_reg(pktout_reg), .return_value(return_value),
    .result_pending(result_pending), .pkt_in_flight(pkt_in_flight));

  wombat_pkt_stats #(.CNT_WIDTH(3), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .result_valid(result_valid), .result_data(result_data),
    .pktin_reg_clear(pktin_reg_clear), .pktout_reg_clear(pktout_reg_clear),
    .return_value_clear(return_value_clear),
    .pktin_reg(s_pktin), .pktout_reg(s_pktout), .return_value(s_rv),
    .result_pending(s_pend), .pkt_in_flight(s_fl));

  wombat_pkt_stats #(.CNT_WIDTH(3), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .result_valid(result_valid), .result_data(result_data),
    .pktin_reg_clear(pktin_reg_clear), .pktout_reg_clear(pktout_reg_clear),
    .return_value_clear(return_value_clear),
    .pktin_reg(w_pktin), .pktout_reg(w_pktout), .return_value(w_rv),
    .result_pending(w_pend), .pkt_in_flight(w_fl));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Expected-value model for the three ingress counters.
  int exp_in = 0, exp_s = 0, exp_w = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return pktin_reg;
      1:       return pktout_reg;
      2:       return return_value;
      3:       return {31'd0, result_pending};
      4:       return {31'd0, pkt_in_flight};
      5:       return {29'd0, s_pktin};
      6:       return {29'd0, w_pktin};
      default: return {29'd0, w_pktout};
    endcase
  endfunction

  // Monitor: compare every queued expectation in the cycle it is due.
  always @(negedge clk) begin
    exp_t item;
    while (q.size() > 0 && (q[0].cyc <= cyc || done)) begin
      logic [31:0] act;
      item = q.pop_front();
      act = observe(item.sel);
      checks++;
      if (item.cyc != cyc) begin
        errors++;
        $display("FAIL %s: not checked in cycle %0d (now %0d), actual %h required %h",
                 item.name, item.cyc, cyc, act, item.val);
      end else if (act !== item.val) begin
        errors++;
        $display("FAIL %s: cycle %0d actual %h required %h", item.name, cyc, act, item.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue a value that must be visible after the next clock edge.
  task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
    q.push_back('{cyc + 1, sel, v, nm});
  endtask

  task automatic bump_in();
    exp_in = exp_in + 1;
    exp_s  = (exp_s == 7) ? 7 : exp_s + 1;
    exp_w  = (exp_w + 1) % 8;
  endtask

  task automatic expect_in_counts(input string nm);
    expect_val(0, 32'(exp_in), nm);
    expect_val(5, 32'(exp_s), {nm, "_sat3"});
    expect_val(6, 32'(exp_w), {nm, "_wrap3"});
  endtask

  task automatic send_in(input int beats);
    for (int b = 0; b < beats; b++) begin
      in_tvalid = 1'b1;
      in_tready = 1'b1;
      in_tlast  = (b == beats - 1);
      expect_val(4, {31'd0, (b != beats - 1)}, "in_flight");
      if (b == beats - 1) begin
        bump_in();
        expect_in_counts("pktin_eop");
      end
      step();
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_out(input int beats);
    for (int b = 0; b < beats; b++) begin
      out_tvalid = 1'b1;
      out_tready = 1'b1;
      out_tlast  = (b == beats - 1);
      step();
    end
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
  endtask

  initial begin
    // Reset: every output of every instance must be zero.
    step(); step();
    for (int s = 0; s < 8; s++) expect_val(s, 32'd0, "reset_state");
    step();
    reset = 1'b0;

    // Ingress packets of 4, 1 and 7 beats.
    send_in(4);
    send_in(1);
    send_in(7);
    expect_val(0, 32'd3, "pktin_after_3pkts");
    expect_val(4, 32'd0, "in_flight_idle");
    step();

    // Beat stalled by tready=0 for 5 cycles, then accepted once.
    in_tvalid = 1'b1;
    in_tlast  = 1'b1;
    in_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_val(0, 32'd3, "pktin_stalled");
      step();
    end
    in_tready = 1'b1;
    bump_in();
    expect_in_counts("pktin_accept");
    step();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    expect_val(0, 32'd4, "pktin_after_stall");
    step();

    // Egress: 5 packets, then clear coincident with a packet end.
    send_out(2);
    send_out(1);
    send_out(1);
    send_out(1);
    send_out(1);
    expect_val(1, 32'd5, "pktout_5");
    step();
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b1;
    pktout_reg_clear = 1'b1;
    expect_val(1, 32'd1, "pktout_clear_and_eop");
    step();
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    expect_val(1, 32'd0, "pktout_clear_only");
    step();
    pktout_reg_clear = 1'b0;
    expect_val(1, 32'd0, "pktout_after_clear");
    step();

    // Saturation / wrap on the 3-bit instances: clear, climb to 6, add 3.
    pktin_reg_clear = 1'b1;
    exp_in = 0; exp_s = 0; exp_w = 0;
    expect_in_counts("pktin_clear");
    step();
    pktin_reg_clear = 1'b0;
    for (int i = 0; i < 6; i++) send_in(1);
    expect_val(5, 32'd6, "sat3_at_6");
    step();
    send_in(1);
    send_in(1);
    send_in(2);
    expect_val(5, 32'd7, "sat3_stuck");
    expect_val(6, 32'd1, "wrap3_wrapped");
    expect_val(0, 32'd9, "pktin_9");
    step();
    pktin_reg_clear = 1'b1;
    in_tvalid = 1'b1;
    in_tlast  = 1'b1;
    exp_in = 1; exp_s = 1; exp_w = 1;
    expect_in_counts("sat_clear_and_eop");
    step();
    pktin_reg_clear = 1'b0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;

    // Result latch.
    result_valid = 1'b1;
    result_data  = 32'h0000_00A5;
    expect_val(2, 32'h0000_00A5, "rv_latch");
    expect_val(3, 32'd1, "pending_set");
    step();
    result_valid = 1'b0;
    return_value_clear = 1'b1;
    expect_val(2, 32'd0, "rv_clear");
    expect_val(3, 32'd0, "pending_clear");
    step();
    result_valid = 1'b1;
    result_data  = 32'h0000_1234;
    expect_val(2, 32'h0000_1234, "rv_clear_vs_new");
    expect_val(3, 32'd1, "pending_clear_vs_new");
    step();
    return_value_clear = 1'b0;
    result_data = 32'h0000_5678;
    expect_val(2, 32'h0000_5678, "rv_overwrite");
    step();
    result_valid = 1'b0;
    expect_val(2, 32'h0000_5678, "rv_hold");
    step();

    // Reset after beat 3 of a 6-beat packet, then a 2-beat packet.
    in_tvalid = 1'b1;
    in_tready = 1'b1;
    in_tlast  = 1'b0;
    step(); step();
    expect_val(4, 32'd1, "in_flight_mid");
    step();
    in_tvalid = 1'b0;
    reset = 1'b1;
    exp_in = 0; exp_s = 0; exp_w = 0;
    expect_val(4, 32'd0, "in_flight_reset");
    expect_val(2, 32'd0, "rv_reset");
    expect_val(3, 32'd0, "pending_reset");
    expect_val(7, 32'd0, "pktout_wrap3_reset");
    expect_in_counts("pktin_reset");
    step();
    reset = 1'b0;
    send_in(2);
    expect_val(0, 32'd1, "pktin_after_reset");
    step();

    step(); step();
    done = 1'b1;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
